// File: rtl/expmul_accum.sv
// expmul_accum: online-softmax exp-multiply stage holding running max m, denominator l and O lanes.
// Optional EXPMUL_ACC_SAT_EN: saturating o/l adds with a per-row sticky sat_flag.

module expmul_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int SH_W   = 5
) (
  input  logic                     first,
  input  logic                     s_gt,
  input  logic [SH_W-1:0]          sh,
  input  logic signed [ACC_W-1:0]  o_cur,
  input  logic signed [DATA_W-1:0] v,
  output logic signed [ACC_W-1:0]  o_nxt,
  output logic                     sat
);
  logic signed [ACC_W-1:0] vx, a, b;
`ifdef EXPMUL_ACC_SAT_EN
  logic signed [ACC_W:0] sum;
`endif

  always_comb begin
    vx  = ACC_W'(v);
    // the larger-score side keeps full weight, the other is rescaled by 2^-sh
    a   = s_gt ? (o_cur >>> sh) : o_cur;
    b   = s_gt ? vx : (vx >>> sh);
    sat = 1'b0;
`ifdef EXPMUL_ACC_SAT_EN
    sum   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    o_nxt = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat   = 1'b1;
      o_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    o_nxt = a + b;
`endif
    if (first) begin
      o_nxt = vx;
      sat   = 1'b0;
    end
  end
endmodule

module expmul_accum #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 24,
  parameter int SCORE_W = 12,
  parameter int L_W     = 20,
  parameter int L_FRAC  = 8,
  parameter int MAX_SEQ = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_SEQ+1)-1:0]   seq_len,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic signed [SCORE_W-1:0]      s_in,
  input  logic [VEC_LEN*DATA_W-1:0]      v_in,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [VEC_LEN*ACC_W-1:0]       o_out,
  output logic [L_W-1:0]                 l_out,
  output logic signed [SCORE_W-1:0]      m_out,
  output logic                           sat_flag
);
  localparam int CNT_W = $clog2(MAX_SEQ+1);
  localparam int SH_W  = $clog2(ACC_W);
  localparam logic [L_W-1:0] ONE = L_W'(1) << L_FRAC;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]                cnt, eff_len;
  logic signed [SCORE_W-1:0]       m_q, m_nxt;
  logic [L_W-1:0]                  l_q, l_nxt, l_a, l_b;
  logic [VEC_LEN-1:0][ACC_W-1:0]   o_q, o_nxt;
  logic [VEC_LEN-1:0]              lane_sat;
  logic                            sat_q, sat_nxt, l_sat;
  logic                            accept, first, s_gt;
  logic signed [SCORE_W:0]         diff;
  logic [SCORE_W:0]                dabs;
  logic [SH_W-1:0]                 sh;
`ifdef EXPMUL_ACC_SAT_EN
  logic [L_W:0]                    l_sum;
`endif

  assign in_rdy  = (state != DONE) || out_rdy;
  assign out_vld = (state == DONE);
  assign accept  = in_vld && in_rdy;
  assign first   = (state != ACCUM);

  always_comb begin
    eff_len = seq_len;
    if (seq_len > CNT_W'(MAX_SEQ)) eff_len = CNT_W'(MAX_SEQ);
    if (seq_len == '0)             eff_len = CNT_W'(1);
  end

  // score distance at SCORE_W+1 bits so extreme scores cannot wrap
  always_comb begin
    diff = {s_in[SCORE_W-1], s_in} - {m_q[SCORE_W-1], m_q};
    s_gt = !diff[SCORE_W] && (diff != '0);
    dabs = diff[SCORE_W] ? -diff : diff;
    sh   = (dabs > (SCORE_W+1)'(ACC_W-1)) ? SH_W'(ACC_W-1) : dabs[SH_W-1:0];
  end

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    expmul_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SH_W(SH_W)) u_lane (
      .first (first),
      .s_gt  (s_gt),
      .sh    (sh),
      .o_cur (o_q[i]),
      .v     (v_in[i*DATA_W +: DATA_W]),
      .o_nxt (o_nxt[i]),
      .sat   (lane_sat[i])
    );
  end

  always_comb begin
    l_a   = s_gt ? (l_q >> sh) : l_q;
    l_b   = s_gt ? ONE : (ONE >> sh);
    l_sat = 1'b0;
`ifdef EXPMUL_ACC_SAT_EN
    l_sum = {1'b0, l_a} + {1'b0, l_b};
    l_sat = l_sum[L_W];
    l_nxt = l_sum[L_W] ? '1 : l_sum[L_W-1:0];
`else
    l_nxt = l_a + l_b;
`endif
    if (first) begin
      l_nxt = ONE;
      l_sat = 1'b0;
    end
    m_nxt   = (first || s_gt) ? s_in : m_q;
    sat_nxt = first ? 1'b0 : (sat_q | l_sat | (|lane_sat));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (eff_len == CNT_W'(1)) ? DONE : ACCUM;
      ACCUM: if (accept && cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: begin
        if (accept)       state_nxt = (eff_len == CNT_W'(1)) ? DONE : ACCUM;
        else if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      m_q      <= '0;
      l_q      <= '0;
      o_q      <= '0;
      sat_q    <= 1'b0;
      o_out    <= '0;
      l_out    <= '0;
      m_out    <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      cnt   <= first ? (eff_len - 1'b1) : (cnt - 1'b1);
      m_q   <= m_nxt;
      l_q   <= l_nxt;
      o_q   <= o_nxt;
      sat_q <= sat_nxt;
      // presented results change only when a row completes
      if (state_nxt == DONE) begin
        o_out    <= o_nxt;
        l_out    <= l_nxt;
        m_out    <= m_nxt;
        sat_flag <= sat_nxt;
      end
    end
  end
endmodule

// File: tb/tb_expmul_accum.sv
// Scoreboard bench for expmul_accum; a 16-bit-accumulator instance covers wrap/saturation.
module tb_expmul_accum;
  localparam int VL = 8, DW = 16, AW = 24, SW = 12, LW = 20, LF = 8, MS = 256;
  localparam int CW = $clog2(MS+1);

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0]    seq_len = '0;
  logic             in_vld = 1'b0, in_rdy, out_vld, out_rdy = 1'b1, sat_flag;
  logic [SW-1:0]    s_in = '0, m_out;
  logic [VL*DW-1:0] v_in = '0;
  logic [VL*AW-1:0] o_out;
  logic [LW-1:0]    l_out;

  expmul_accum dut (
    .clk(clk), .rst(rst), .seq_len(seq_len), .in_vld(in_vld), .in_rdy(in_rdy),
    .s_in(s_in), .v_in(v_in), .out_vld(out_vld), .out_rdy(out_rdy),
    .o_out(o_out), .l_out(l_out), .m_out(m_out), .sat_flag(sat_flag)
  );

  logic [CW-1:0] seq16 = '0;
  logic          vld16 = 1'b0, rdy16, ovld16, ordy16 = 1'b1, sat16;
  logic [SW-1:0] s16 = '0, m16;
  logic [31:0]   v16 = '0, o16;
  logic [LW-1:0] l16;

  expmul_accum #(.VEC_LEN(2), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .seq_len(seq16), .in_vld(vld16), .in_rdy(rdy16),
    .s_in(s16), .v_in(v16), .out_vld(ovld16), .out_rdy(ordy16),
    .o_out(o16), .l_out(l16), .m_out(m16), .sat_flag(sat16)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [VL*AW-1:0] o;
    logic [LW-1:0]    l;
    logic [SW-1:0]    m;
    logic             sat;
  } exp_t;
  exp_t sb_q[$];

  longint mo[VL];
  longint ml;
  int     mm, rem = 0;
  bit     msat;

  task automatic fit_o(inout longint x);
`ifdef EXPMUL_ACC_SAT_EN
    if (x > (longint'(1) << (AW-1)) - 1) begin x = (longint'(1) << (AW-1)) - 1; msat = 1; end
    else if (x < -(longint'(1) << (AW-1))) begin x = -(longint'(1) << (AW-1)); msat = 1; end
`else
    x = x & ((longint'(1) << AW) - 1);
    if (x >= (longint'(1) << (AW-1))) x = x - (longint'(1) << AW);
`endif
  endtask

  task automatic fit_l();
`ifdef EXPMUL_ACC_SAT_EN
    if (ml > (longint'(1) << LW) - 1) begin ml = (longint'(1) << LW) - 1; msat = 1; end
`else
    ml = ml & ((longint'(1) << LW) - 1);
`endif
  endtask

  task automatic model_accept(input int s, input logic [VL*DW-1:0] vv, input int sl);
    int d, sh, eff;
    longint v, x;
    exp_t e;
    if (rem == 0) begin
      eff = (sl > MS) ? MS : sl;
      if (eff == 0) eff = 1;
      rem = eff - 1; mm = s; ml = longint'(1) << LF; msat = 0;
      for (int i = 0; i < VL; i++) mo[i] = $signed(vv[i*DW +: DW]);
    end else begin
      rem--;
      d  = s - mm;
      sh = (d < 0) ? -d : d;
      if (sh > AW-1) sh = AW-1;
      for (int i = 0; i < VL; i++) begin
        v = $signed(vv[i*DW +: DW]);
        x = (d > 0) ? ((mo[i] >>> sh) + v) : (mo[i] + (v >>> sh));
        fit_o(x);
        mo[i] = x;
      end
      if (d > 0) begin ml = (ml >> sh) + (longint'(1) << LF); mm = s; end
      else ml = ml + ((longint'(1) << LF) >> sh);
      fit_l();
    end
    if (rem == 0) begin
      for (int i = 0; i < VL; i++) e.o[i*AW +: AW] = mo[i][AW-1:0];
      e.l = ml[LW-1:0]; e.m = SW'(mm); e.sat = msat;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    #1;
    while (!in_rdy && n < 100) begin @(negedge clk); #1; n++; end
    if (!in_rdy) chk("rdy_timeout", in_rdy, 1);
  endtask

  task automatic send(input int s, input logic [VL*DW-1:0] vv, input int sl);
    @(negedge clk);
    in_vld = 1'b1; s_in = SW'(s); v_in = vv; seq_len = CW'(sl);
    wait_rdy();
    @(posedge clk);
    model_accept(s, vv, sl);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  function automatic logic [VL*DW-1:0] splat(input int x);
    logic [VL*DW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = DW'(x);
    return r;
  endfunction

  function automatic logic [VL*DW-1:0] rnd_v();
    logic [VL*DW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && out_vld && out_rdy) begin
      if (sb_q.size() == 0) chk("sb_unexpected", out_vld, 0);
      else begin
        e = sb_q.pop_front();
        chk("o", o_out, e.o);
        chk("l", l_out, e.l);
        chk("m", m_out, e.m);
        chk("sat", sat_flag, e.sat);
      end
    end
  end

  initial begin
    logic [15:0] o16_exp;
    logic        sat16_exp;
    int len;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      chk("rst_vld", out_vld, 0); chk("rst_rdy", in_rdy, 1);
      chk("rst_o", o_out, 0); chk("rst_l", l_out, 0);
      chk("rst_m", m_out, 0); chk("rst_sat", sat_flag, 0);
    end

    // single element, one-cycle latency
    send(5, splat(100), 1);
    #1 chk("lat_vld", out_vld, 1);

    // 2,4,4 with v=64: final o=144, l=576
    send(2, splat(64), 3); send(4, splat(64), 3); send(4, splat(64), 3);

    // backpressure in DONE, then zero-bubble turnover
    @(negedge clk) out_rdy = 1'b0;
    send(3, rnd_v(), 2); send(1, rnd_v(), 2);
    in_vld = 1'b1; s_in = SW'(7); v_in = splat(-3); seq_len = CW'(1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", in_rdy, 0); chk("bp_vld", out_vld, 1);
      chk("bp_o", o_out, sb_q[0].o); chk("bp_l", l_out, sb_q[0].l); chk("bp_m", m_out, sb_q[0].m);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1 chk("turn_rdy", in_rdy, 1);
    @(posedge clk) model_accept(7, splat(-3), 1);
    @(negedge clk) in_vld = 1'b0;
    #1 chk("turn_vld", out_vld, 1);

    // large gap, sh clamps to ACC_W-1
    send(0, splat(-8), 2); send(100, splat(10), 2);

    // seq_len 0 acts as 1; negative score
    send(-5, rnd_v(), 0);

    // random rows, seq_len scrambled after the first element
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send($urandom_range(0, 600) - 300, rnd_v(), (k == 0) ? len : $urandom_range(0, 511));
    end

    // seq_len above MAX_SEQ clamps to 256 elements
    for (int k = 0; k < MS; k++) send($urandom_range(0, 3), rnd_v(), (k == 0) ? 300 : 5);

    repeat (3) @(negedge clk);
    #1 chk("sb_empty", sb_q.size(), 0);

    // reset mid-row aborts without output
    send(1, rnd_v(), 4); send(2, rnd_v(), 4);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rem = 0;
    repeat (3) begin
      #1;
      chk("abort_vld", out_vld, 0); chk("abort_o", o_out, 0); chk("abort_l", l_out, 0);
      @(negedge clk);
    end

    // 16-bit accumulator: four maximal positive adds
`ifdef EXPMUL_ACC_SAT_EN
    o16_exp = 16'h7fff; sat16_exp = 1'b1;
`else
    o16_exp = 16'hfffc; sat16_exp = 1'b0;
`endif
    ordy16 = 1'b0; vld16 = 1'b1; s16 = '0; v16 = {2{16'h7fff}}; seq16 = CW'(4);
    repeat (4) @(negedge clk);
    vld16 = 1'b0;
    #1;
    chk("w16_vld", ovld16, 1); chk("w16_rdy", rdy16, 0);
    chk("w16_o0", o16[15:0], o16_exp); chk("w16_o1", o16[31:16], o16_exp);
    chk("w16_l", l16, 1024); chk("w16_sat", sat16, sat16_exp);
    @(negedge clk) begin ordy16 = 1'b1; vld16 = 1'b1; end
    @(negedge clk) begin rst = 1'b1; vld16 = 1'b0; end
    @(negedge clk) rst = 1'b0;
    #1;
    chk("w16_abort_vld", ovld16, 0); chk("w16_abort_o", o16, 0); chk("w16_abort_sat", sat16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
